// File: rtl/tree_search_walker.sv
// tree_search_walker: single-lookup binary tree walker over a node store.
// Optional TREE_WALK_HOPS_EN adds resp_hops_out (nodes visited per lookup).
module tree_search_walker #(
    parameter int WORD_SIZE    = 16,
    parameter int POINTER_SIZE = 16,
    parameter int MAX_DEPTH    = 16,
    parameter int ROOT_POINTER = 0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    req_valid_in,
    output logic                    req_ready_out,
    input  logic [WORD_SIZE-1:0]    req_key_in,
    output logic                    node_rd_en_out,
    output logic [POINTER_SIZE-1:0] node_addr_out,
    input  logic [WORD_SIZE-1:0]    data_word_in,
    input  logic [POINTER_SIZE-1:0] left_pointer_in,
    input  logic [POINTER_SIZE-1:0] right_pointer_in,
    input  logic                    valid_bit_in,
    input  logic                    left_pointer_valid_bit_in,
    input  logic                    right_pointer_valid_bit_in,
    output logic                    resp_valid_out,
    input  logic                    resp_ready_in,
    output logic                    resp_hit_out,
    output logic [POINTER_SIZE-1:0] resp_pointer_out,
    output logic                    resp_error_out
`ifdef TREE_WALK_HOPS_EN
    ,
    output logic [$clog2(MAX_DEPTH+1)-1:0] resp_hops_out
`endif
);
    localparam int HW = $clog2(MAX_DEPTH + 1);
    localparam logic [HW-1:0] MAXD = HW'(MAX_DEPTH);
    localparam logic [POINTER_SIZE-1:0] ROOT = POINTER_SIZE'(ROOT_POINTER);

    typedef enum logic [1:0] {IDLE, FETCH, EVAL, DONE} state_t;

    state_t                  r_state;
    logic [WORD_SIZE-1:0]    r_key;
    logic [POINTER_SIZE-1:0] r_cur;
    logic [HW-1:0]           r_hops;

    logic [HW-1:0]           w_hops_next;
    logic                    w_eq;
    logic                    w_lt;
    logic                    w_child_ok;
    logic                    w_depth_ok;
    logic [POINTER_SIZE-1:0] w_child;
    logic                    w_stop;

    assign w_hops_next = r_hops + 1'b1;
    assign w_eq        = r_key == data_word_in;
    assign w_lt        = r_key < data_word_in;
    assign w_child_ok  = w_lt ? left_pointer_valid_bit_in : right_pointer_valid_bit_in;
    assign w_child     = w_lt ? left_pointer_in : right_pointer_in;
    assign w_depth_ok  = w_hops_next < MAXD;
    assign w_stop      = !valid_bit_in || w_eq || !w_child_ok || !w_depth_ok;

`ifdef TREE_WALK_HOPS_EN
    assign resp_hops_out = r_hops;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state          <= IDLE;
            r_key            <= '0;
            r_cur            <= '0;
            r_hops           <= '0;
            req_ready_out    <= 1'b1;
            node_rd_en_out   <= 1'b0;
            node_addr_out    <= '0;
            resp_valid_out   <= 1'b0;
            resp_hit_out     <= 1'b0;
            resp_pointer_out <= '0;
            resp_error_out   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (req_valid_in) begin
                    r_key          <= req_key_in;
                    r_cur          <= ROOT;
                    r_hops         <= '0;
                    req_ready_out  <= 1'b0;
                    node_rd_en_out <= 1'b1;
                    node_addr_out  <= ROOT;
                    r_state        <= FETCH;
                end
                FETCH: begin
                    node_rd_en_out <= 1'b0;
                    r_state        <= EVAL;
                end
                EVAL: begin
                    r_hops <= w_hops_next;
                    if (w_stop) begin
                        resp_valid_out   <= 1'b1;
                        resp_hit_out     <= valid_bit_in && w_eq;
                        resp_pointer_out <= (valid_bit_in && w_eq) ? r_cur : '0;
                        // error only when a real child exists but the depth budget is spent
                        resp_error_out   <= valid_bit_in && !w_eq && w_child_ok && !w_depth_ok;
                        r_state          <= DONE;
                    end else begin
                        r_cur          <= w_child;
                        node_rd_en_out <= 1'b1;
                        node_addr_out  <= w_child;
                        r_state        <= FETCH;
                    end
                end
                DONE: if (resp_ready_in) begin
                    resp_valid_out   <= 1'b0;
                    resp_hit_out     <= 1'b0;
                    resp_pointer_out <= '0;
                    resp_error_out   <= 1'b0;
                    req_ready_out    <= 1'b1;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tree_search_walker.sv
// tb_tree_search_walker: directed table plus corner sequences for tree_search_walker.
// The walker is built with MAX_DEPTH=2 so the depth abort is reachable with a short chain.
module tb_tree_search_walker;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        req_valid_in = 1'b0;
    logic        req_ready_out;
    logic [15:0] req_key_in = '0;
    logic        node_rd_en_out;
    logic [15:0] node_addr_out;
    logic [15:0] data_word_in;
    logic [15:0] left_pointer_in;
    logic [15:0] right_pointer_in;
    logic        valid_bit_in;
    logic        left_pointer_valid_bit_in;
    logic        right_pointer_valid_bit_in;
    logic        resp_valid_out;
    logic        resp_ready_in = 1'b0;
    logic        resp_hit_out;
    logic [15:0] resp_pointer_out;
    logic        resp_error_out;

    int compared = 0;
    int mismatched = 0;

    logic [15:0] mem_d [8];
    logic [15:0] mem_l [8];
    logic [15:0] mem_r [8];
    logic        mem_v [8];
    logic        mem_lv[8];
    logic        mem_rv[8];
    logic [2:0]  w_a;

    int          rd_count = 0;
    logic [15:0] addr_log[4];
    int          last_r0;

    tree_search_walker #(.WORD_SIZE(16), .POINTER_SIZE(16), .MAX_DEPTH(2), .ROOT_POINTER(0)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out), .req_key_in(req_key_in),
        .node_rd_en_out(node_rd_en_out), .node_addr_out(node_addr_out),
        .data_word_in(data_word_in), .left_pointer_in(left_pointer_in), .right_pointer_in(right_pointer_in),
        .valid_bit_in(valid_bit_in), .left_pointer_valid_bit_in(left_pointer_valid_bit_in),
        .right_pointer_valid_bit_in(right_pointer_valid_bit_in),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in), .resp_hit_out(resp_hit_out),
        .resp_pointer_out(resp_pointer_out), .resp_error_out(resp_error_out)
    );

    always #5 clk_in = ~clk_in;

    // node store: address is held through EVAL, so data can follow it combinationally
    assign w_a                        = 3'(node_addr_out);
    assign data_word_in               = mem_d[w_a];
    assign left_pointer_in            = mem_l[w_a];
    assign right_pointer_in           = mem_r[w_a];
    assign valid_bit_in               = mem_v[w_a];
    assign left_pointer_valid_bit_in  = mem_lv[w_a];
    assign right_pointer_valid_bit_in = mem_rv[w_a];

    always @(posedge clk_in) if (node_rd_en_out) begin
        addr_log[rd_count % 4] <= node_addr_out;
        rd_count <= rd_count + 1;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        compared++;
        if (a !== e) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic set_node(input int i, input logic [15:0] d, input logic [15:0] l, input logic [15:0] r,
                            input logic v, input logic lv, input logic rv);
        mem_d[i] = d; mem_l[i] = l; mem_r[i] = r; mem_v[i] = v; mem_lv[i] = lv; mem_rv[i] = rv;
    endtask

    task automatic std_tree();
        for (int i = 0; i < 8; i++) set_node(i, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        set_node(0, 16'h0050, 16'h0001, 16'h0002, 1'b1, 1'b1, 1'b1);
        set_node(1, 16'h0020, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
        set_node(2, 16'h0080, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic lookup(input logic [15:0] key, input int hold, output logic hit, output logic [15:0] ptr,
                          output logic err, output int lat, output int reads);
        int  cnt;
        bit  seen;
        @(negedge clk_in);
        chk("req_ready_idle", {31'b0, req_ready_out}, 32'd1);
        req_key_in   = key;
        req_valid_in = 1'b1;
        last_r0      = rd_count;
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
        req_key_in   = 16'hDEAD;
        cnt = 0;
        seen = 0;
        while (!seen && cnt < 40) begin
            @(posedge clk_in);
            #1;
            cnt++;
            seen = resp_valid_out;
        end
        if (!seen) begin
            mismatched++;
            $display("FAIL resp_timeout: got no resp_valid_out after %0d cycles, required within 40", cnt);
        end
        lat   = cnt + 1;
        reads = rd_count - last_r0;
        hit   = resp_hit_out;
        ptr   = resp_pointer_out;
        err   = resp_error_out;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk_in);
            #1;
            chk("bp_valid", {31'b0, resp_valid_out}, 32'd1);
            chk("bp_req_ready", {31'b0, req_ready_out}, 32'd0);
            chk("bp_stable", {15'b0, resp_hit_out, resp_pointer_out, resp_error_out}, {15'b0, hit, ptr, err});
        end
        resp_ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        resp_ready_in = 1'b0;
        chk("valid_cleared", {31'b0, resp_valid_out}, 32'd0);
        chk("ready_back", {31'b0, req_ready_out}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] key;
        logic        hit;
        logic [15:0] ptr;
        logic        err;
        int          lat;
        int          reads;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic        hit, err;
        logic [15:0] ptr;
        int          lat, reads;
        vt[0] = '{16'h0050, 1'b1, 16'h0000, 1'b0, 3, 1};
        vt[1] = '{16'h0020, 1'b1, 16'h0001, 1'b0, 5, 2};
        vt[2] = '{16'h0080, 1'b1, 16'h0002, 1'b0, 5, 2};
        vt[3] = '{16'h0010, 1'b0, 16'h0000, 1'b0, 5, 2};
        vt[4] = '{16'h0030, 1'b0, 16'h0000, 1'b0, 5, 2};
        vt[5] = '{16'h0051, 1'b0, 16'h0000, 1'b0, 5, 2};
        vt[6] = '{16'h0090, 1'b0, 16'h0000, 1'b0, 5, 2};
        std_tree();

        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_ready", {31'b0, req_ready_out}, 32'd1);
        chk("rst_outs", {11'b0, resp_valid_out, node_rd_en_out, resp_hit_out, resp_error_out, resp_pointer_out, node_addr_out}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        for (int i = 0; i < 7; i++) begin
            lookup(vt[i].key, 0, hit, ptr, err, lat, reads);
            chk($sformatf("v%0d_hit", i), {31'b0, hit}, {31'b0, vt[i].hit});
            chk($sformatf("v%0d_ptr", i), {16'b0, ptr}, {16'b0, vt[i].ptr});
            chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vt[i].err});
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_reads", i), reads, vt[i].reads);
        end

        lookup(16'h0020, 0, hit, ptr, err, lat, reads);
        chk("walk_addr0", {16'b0, addr_log[last_r0 % 4]}, 32'h0000);
        chk("walk_addr1", {16'b0, addr_log[(last_r0 + 1) % 4]}, 32'h0001);

        mem_rv[0] = 1'b0;
        lookup(16'h0060, 0, hit, ptr, err, lat, reads);
        chk("miss_noright", {14'b0, hit, err, ptr}, 32'h0);
        chk("miss_noright_lat", lat, 3);
        mem_v[0] = 1'b0;
        lookup(16'h0050, 0, hit, ptr, err, lat, reads);
        chk("miss_empty_root", {14'b0, hit, err, ptr}, 32'h0);
        chk("miss_empty_reads", reads, 1);

        for (int i = 0; i < 8; i++) set_node(i, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        set_node(0, 16'h0010, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1);
        set_node(1, 16'h0020, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b1);
        set_node(2, 16'h0030, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b1);
        lookup(16'hFFFF, 0, hit, ptr, err, lat, reads);
        chk("depth_err", {31'b0, err}, 32'd1);
        chk("depth_hit", {31'b0, hit}, 32'd0);
        chk("depth_ptr", {16'b0, ptr}, 32'd0);
        chk("depth_reads", reads, 2);

        std_tree();
        lookup(16'h0050, 4, hit, ptr, err, lat, reads);
        chk("bp_hit", {15'b0, hit, ptr}, 32'h10000);
        lookup(16'h0080, 0, hit, ptr, err, lat, reads);
        chk("bp_next_hit", {15'b0, hit, ptr}, 32'h10002);

        @(negedge clk_in);
        req_key_in   = 16'h0020;
        req_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
        chk("fetch_strobe", {31'b0, node_rd_en_out}, 32'd1);
        #1 rst_in = 1'b1;
        #1;
        chk("rst_mid_ready", {31'b0, req_ready_out}, 32'd1);
        chk("rst_mid_outs", {30'b0, resp_valid_out, node_rd_en_out}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        begin
            int late = 0;
            repeat (6) begin
                @(posedge clk_in);
                #1;
                late += resp_valid_out;
            end
            chk("rst_no_resp", late, 0);
        end
        lookup(16'h0020, 0, hit, ptr, err, lat, reads);
        chk("post_rst_hit", {15'b0, hit, ptr}, 32'h10001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
